composite_sync_generator: RTL and testbench

COMPOSITE_SYNC_GENERATOR -- requirements
Module: composite_sync_generator

---
 rtl/composite_sync_generator.sv | 159 +++++++++++++++
 tb/tb_composite_sync_generator.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/composite_sync_generator.sv
// Composite video sync/blanking generator: walks a progressive raster on the DAC
// strobe and emits sync tips, broad vsync pulses, burst gate and clamped active luma.
module composite_sync_generator #(
  parameter int                DATA_W           = 12,
  parameter int                LINE_TICKS       = 2354,
  parameter int                LINES_PER_FRAME  = 262,
  parameter int                HSYNC_WIDTH      = 174,
  parameter int                BACK_PORCH       = 222,
  parameter int                ACTIVE_WIDTH     = 1920,
  parameter int                BURST_START      = 196,
  parameter int                BURST_END        = 288,
  parameter int                VSYNC_FIRST_LINE = 3,
  parameter int                VSYNC_LINES      = 3,
  parameter int                BROAD_WIDTH      = 1000,
  parameter logic [DATA_W-1:0] SYNC_LEVEL       = 12'h100,
  parameter logic [DATA_W-1:0] BLANK_LEVEL      = 12'h400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic              enable,
  input  logic [DATA_W-1:0] pixel_luma,
  output logic [DATA_W-1:0] dac_data,
  output logic              pixel_req,
  output logic              h_sync_pulse,
  output logic              v_sync_pulse,
  output logic              active_video,
  output logic              burst_gate,
  output logic [11:0]       x_coord,
  output logic [9:0]        y_coord
);

  localparam int ACT_LO    = HSYNC_WIDTH + BACK_PORCH;
  localparam int ACT_HI    = ACT_LO + ACTIVE_WIDTH;
  localparam int HALF_LINE = LINE_TICKS / 2;

  logic [11:0]       h_count_q, h_count_d;
  logic [9:0]        v_count_q, v_count_d;
  logic              armed_q, armed_d;
  logic [DATA_W-1:0] dac_q, dac_d;
  logic              preq_q, preq_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              act_q, act_d;
  logic              burst_q, burst_d;
  logic              wrap_h, wrap_v;

  function automatic logic vsync_line(input logic [9:0] v);
    return (int'(v) >= VSYNC_FIRST_LINE) && (int'(v) < VSYNC_FIRST_LINE + VSYNC_LINES);
  endfunction

  function automatic logic in_active(input logic [11:0] h, input logic [9:0] v);
    return !vsync_line(v) && (int'(h) > ACT_LO) && (int'(h) <= ACT_HI);
  endfunction

  function automatic logic in_burst(input logic [11:0] h, input logic [9:0] v);
    return !vsync_line(v) && (int'(h) > BURST_START) && (int'(h) < BURST_END);
  endfunction

  // Broad lines carry two equalising-free broad pulses, one per half-line.
  function automatic logic in_sync(input logic [11:0] h, input logic [9:0] v);
    if (vsync_line(v))
      return (int'(h) < BROAD_WIDTH) ||
             ((int'(h) >= HALF_LINE) && (int'(h) < HALF_LINE + BROAD_WIDTH));
    return int'(h) < HSYNC_WIDTH;
  endfunction

  function automatic logic [DATA_W-1:0] clamp_luma(input logic [DATA_W-1:0] x);
    return (x < BLANK_LEVEL) ? BLANK_LEVEL : x;
  endfunction

  assign wrap_h = (int'(h_count_q) == LINE_TICKS - 1);
  assign wrap_v = (int'(v_count_q) == LINES_PER_FRAME - 1);

  always_comb begin
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    armed_d   = armed_q;
    dac_d     = dac_q;
    preq_d    = preq_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    act_d     = act_q;
    burst_d   = burst_q;
    if (sample_valid) begin
      if (!enable) begin
        h_count_d = '0;
        v_count_d = '0;
        armed_d   = 1'b1;
        dac_d     = BLANK_LEVEL;
        preq_d    = 1'b0;
        hs_d      = 1'b0;
        vs_d      = 1'b0;
        act_d     = 1'b0;
        burst_d   = 1'b0;
      end else if (armed_q) begin
        // First enabled strobe only announces line 0; sampling starts on the next one.
        h_count_d = '0;
        v_count_d = '0;
        armed_d   = 1'b0;
        dac_d     = BLANK_LEVEL;
        hs_d      = 1'b1;
        vs_d      = 1'b1;
        act_d     = 1'b0;
        burst_d   = 1'b0;
        preq_d    = in_active(h_count_d, v_count_d);
      end else begin
        h_count_d = wrap_h ? 12'd0 : h_count_q + 12'd1;
        if (wrap_h)
          v_count_d = wrap_v ? 10'd0 : v_count_q + 10'd1;
        hs_d    = wrap_h;
        vs_d    = wrap_h && wrap_v;
        act_d   = in_active(h_count_q, v_count_q);
        burst_d = in_burst(h_count_q, v_count_q);
        if (act_d)
          dac_d = clamp_luma(pixel_luma);
        else if (in_sync(h_count_q, v_count_q))
          dac_d = SYNC_LEVEL;
        else
          dac_d = BLANK_LEVEL;
        preq_d = in_active(h_count_d, v_count_d);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_count_q <= '0;
      v_count_q <= '0;
      armed_q   <= 1'b1;
      dac_q     <= BLANK_LEVEL;
      preq_q    <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      act_q     <= 1'b0;
      burst_q   <= 1'b0;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      armed_q   <= armed_d;
      dac_q     <= dac_d;
      preq_q    <= preq_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      act_q     <= act_d;
      burst_q   <= burst_d;
    end
  end

  assign dac_data     = dac_q;
  assign pixel_req    = preq_q;
  assign h_sync_pulse = hs_q;
  assign v_sync_pulse = vs_q;
  assign active_video = act_q;
  assign burst_gate   = burst_q;
  assign x_coord      = h_count_q;
  assign y_coord      = v_count_q;

endmodule

// File: tb/tb_composite_sync_generator.sv
// Scoreboard bench for composite_sync_generator on a reduced 100x10 raster.
module tb_composite_sync_generator;

  localparam int          T_LT    = 100;
  localparam int          T_LPF   = 10;
  localparam logic [11:0] T_SYNC  = 12'h100;
  localparam logic [11:0] T_BLANK = 12'h400;
  // Raster landmarks for the reduced geometry below, worked out by hand.
  localparam int T_SYNC_LAST   = 7;
  localparam int T_ACT_FIRST   = 19;
  localparam int T_ACT_LAST    = 78;
  localparam int T_BURST_FIRST = 11;
  localparam int T_BURST_LAST  = 15;
  localparam int T_BRA_LAST    = 29;
  localparam int T_BRB_FIRST   = 50;
  localparam int T_BRB_LAST    = 79;

  typedef struct packed {
    logic [11:0] dac;
    logic        preq;
    logic        hs;
    logic        vs;
    logic        act;
    logic        burst;
    logic [11:0] x;
    logic [9:0]  y;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic        enable;
  logic [11:0] pixel_luma;
  logic [11:0] dac_data;
  logic        pixel_req, h_sync_pulse, v_sync_pulse, active_video, burst_gate;
  logic [11:0] x_coord;
  logic [9:0]  y_coord;

  composite_sync_generator #(
    .DATA_W(12), .LINE_TICKS(100), .LINES_PER_FRAME(10), .HSYNC_WIDTH(8),
    .BACK_PORCH(10), .ACTIVE_WIDTH(60), .BURST_START(10), .BURST_END(16),
    .VSYNC_FIRST_LINE(3), .VSYNC_LINES(2), .BROAD_WIDTH(30),
    .SYNC_LEVEL(12'h100), .BLANK_LEVEL(12'h400)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .enable(enable),
    .pixel_luma(pixel_luma), .dac_data(dac_data), .pixel_req(pixel_req),
    .h_sync_pulse(h_sync_pulse), .v_sync_pulse(v_sync_pulse),
    .active_video(active_video), .burst_gate(burst_gate),
    .x_coord(x_coord), .y_coord(y_coord)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   printed = 0;
  rec_t q[$];
  rec_t cur;
  rec_t rst_rec;
  bit   have = 0;
  bit   strobe_seen = 0;
  bit   m_armed = 1;
  int   m_pos = 0;

  int n_hs, n_vs, n_preq, n_act, n_burst, n_sync, n_blank, n_val;
  int n_run8, n_run30, n_runbad, run;
  logic [11:0] stat_val;

  function automatic bit m_vline(input int p);
    int v;
    v = (p / T_LT) % T_LPF;
    return (v == 3) || (v == 4);
  endfunction

  function automatic bit m_act(input int p);
    int h;
    h = p % T_LT;
    return !m_vline(p) && (h >= T_ACT_FIRST) && (h <= T_ACT_LAST);
  endfunction

  function automatic rec_t model_step(input bit en, input logic [11:0] luma);
    rec_t r;
    int   h;
    r     = '0;
    r.dac = T_BLANK;
    if (!en) begin
      m_armed = 1;
    end else if (m_armed) begin
      m_armed = 0;
      m_pos   = 0;
      r.hs    = 1'b1;
      r.vs    = 1'b1;
      r.preq  = m_act(0);
    end else begin
      h       = m_pos % T_LT;
      r.act   = m_act(m_pos);
      r.burst = !m_vline(m_pos) && (h >= T_BURST_FIRST) && (h <= T_BURST_LAST);
      if (r.act)
        r.dac = (luma >= T_BLANK) ? luma : T_BLANK;
      else if (m_vline(m_pos) ? (h <= T_BRA_LAST || (h >= T_BRB_FIRST && h <= T_BRB_LAST))
                              : (h <= T_SYNC_LAST))
        r.dac = T_SYNC;
      m_pos  = m_pos + 1;
      r.x    = 12'(m_pos % T_LT);
      r.y    = 10'((m_pos / T_LT) % T_LPF);
      r.hs   = (r.x == 12'd0);
      r.vs   = (r.x == 12'd0) && (r.y == 10'd0);
      r.preq = m_act(m_pos);
    end
    return r;
  endfunction

  always @(posedge clk) strobe_seen <= sample_valid && !rst;

  always @(negedge clk) begin
    rec_t d;
    d = {dac_data, pixel_req, h_sync_pulse, v_sync_pulse, active_video, burst_gate,
         x_coord, y_coord};
    if (rst) begin
      cur  = rst_rec;
      have = 1;
    end else if (strobe_seen) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: DUT strobe with no expected entry at t=%0t", $time);
      end else begin
        cur  = q.pop_front();
        have = 1;
      end
      if (h_sync_pulse) n_hs++;
      if (v_sync_pulse) n_vs++;
      if (pixel_req) n_preq++;
      if (active_video) n_act++;
      if (burst_gate) n_burst++;
      if (dac_data == stat_val) n_val++;
      if (dac_data == T_SYNC) begin
        n_sync++;
        run++;
      end else begin
        if (run == 8) n_run8++;
        else if (run == 30) n_run30++;
        else if (run != 0) n_runbad++;
        run = 0;
        if (dac_data == T_BLANK) n_blank++;
      end
    end
    if (have) begin
      total++;
      if (d != cur) begin
        bad++;
        if (printed < 30) begin
          printed++;
          $display("FAIL sb t=%0t got dac=%h pr=%b hs=%b vs=%b av=%b bg=%b x=%0d y=%0d exp dac=%h pr=%b hs=%b vs=%b av=%b bg=%b x=%0d y=%0d",
                   $time, d.dac, d.preq, d.hs, d.vs, d.act, d.burst, d.x, d.y,
                   cur.dac, cur.preq, cur.hs, cur.vs, cur.act, cur.burst, cur.x, cur.y);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic step(input bit sv, input bit en, input logic [11:0] luma);
    @(posedge clk);
    #1;
    sample_valid = sv;
    enable       = en;
    pixel_luma   = luma;
    if (sv) q.push_back(model_step(en, luma));
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic clr_stats(input logic [11:0] val);
    n_hs = 0; n_vs = 0; n_preq = 0; n_act = 0; n_burst = 0; n_sync = 0;
    n_blank = 0; n_val = 0; n_run8 = 0; n_run30 = 0; n_runbad = 0; run = 0;
    stat_val = val;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pat [4];
    pat = '{12'h3FF, 12'h400, 12'h401, 12'hFFF};
    rst_rec = '0;
    rst_rec.dac = T_BLANK;
    clr_stats(12'h000);
    rst = 1'b0; sample_valid = 1'b0; enable = 1'b0; pixel_luma = '0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dac", dac_data, T_BLANK);
    chk("rst_x", x_coord, 0);
    chk("rst_y", y_coord, 0);
    chk("rst_preq", pixel_req, 0);
    chk("rst_hs", h_sync_pulse, 0);
    chk("rst_vs", v_sync_pulse, 0);
    chk("rst_active", active_video, 0);
    chk("rst_burst", burst_gate, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Full frame of constant bright luma after the restart strobe.
    clr_stats(12'hA00);
    for (int i = 0; i < 1001; i++) step(1'b1, 1'b1, 12'hA00);
    drain();
    chk("frame_hs", n_hs, 11);
    chk("frame_vs", n_vs, 2);
    chk("frame_preq", n_preq, 480);
    chk("frame_active", n_act, 480);
    chk("frame_luma_a00", n_val, 480);
    chk("frame_burst", n_burst, 40);
    chk("frame_sync", n_sync, 184);
    chk("frame_runs8", n_run8, 8);
    chk("frame_runs30", n_run30, 4);
    chk("frame_runs_other", n_runbad, 0);

    // Dark luma below blank must clamp.
    clr_stats(12'h050);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 12'h050);
    drain();
    chk("clamp_luma050", n_val, 0);
    chk("clamp_blank", n_blank, 92);
    chk("clamp_active", n_act, 60);

    // Lumas straddling the clamp threshold.
    clr_stats(12'h401);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, pat[i % 4]);
    drain();
    chk("edge_luma401", n_val, 15);
    chk("edge_blank", n_blank, 62);

    // Strobe on every other cycle; outputs must hold in between.
    clr_stats(12'h800);
    for (int i = 0; i < 200; i++) step(i % 2 == 0, 1'b1, 12'h800);
    drain();
    chk("slow_hs", n_hs, 1);
    chk("slow_preq", n_preq, 60);
    chk("slow_sync", n_sync, 8);

    // Advance to line 5, h=50, then drop enable.
    for (int i = 0; i < 250; i++) step(1'b1, 1'b1, 12'h600);
    drain();
    chk("pre_drop_x", x_coord, 50);
    chk("pre_drop_y", y_coord, 5);
    clr_stats(12'h000);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 12'h600);
    drain();
    chk("off_blank", n_blank, 20);
    chk("off_hs", n_hs, 0);
    chk("off_preq", n_preq, 0);
    chk("off_x", x_coord, 0);
    chk("off_y", y_coord, 0);
    clr_stats(12'h000);
    for (int i = 0; i < 101; i++) step(1'b1, 1'b1, 12'h600);
    drain();
    chk("restart_vs", n_vs, 1);
    chk("restart_hs", n_hs, 2);
    chk("restart_sync", n_sync, 8);
    chk("restart_preq", n_preq, 60);

    // Asynchronous reset in the middle of a sync tip.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 12'h700);
    drain();
    chk("pre_rst_dac", dac_data, T_SYNC);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_dac", dac_data, T_BLANK);
    chk("async_rst_x", x_coord, 0);
    chk("async_rst_y", y_coord, 0);
    m_armed = 1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    clr_stats(12'h000);
    for (int i = 0; i < 50; i++) step(1'b1, 1'b1, 12'h700);
    drain();
    chk("post_rst_vs", n_vs, 1);
    chk("post_rst_hs", n_hs, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
